alu_issue: RTL and testbench

//  Execute-stage sequencer that drives the combinational 8-bit ALU.

---
 rtl/alu_issue_if.sv | 24 ++
 rtl/alu_issue.sv | 115 +++++++++++
 tb/tb_alu_issue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Instruction handshake and ALU operand/result bus shared by the issue sequencer
// (master) and the environment that supplies instructions and the combinational ALU (slave).
interface alu_issue_if #(
   parameter int M_WIDTH = 8
);
   logic               instr_valid;
   logic               instr_ready;
   logic [31:0]        instr;
   logic [2:0]         alu_funct3;
   logic               alu_modifier;
   logic [M_WIDTH-1:0] alu_in1;
   logic [M_WIDTH-1:0] alu_in2;
   logic [M_WIDTH-1:0] alu_out;

   modport master (
      input  instr_valid, instr, alu_out,
      output instr_ready, alu_funct3, alu_modifier, alu_in1, alu_in2
   );

   modport slave (
      output instr_valid, instr, alu_out,
      input  instr_ready, alu_funct3, alu_modifier, alu_in1, alu_in2
   );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage sequencer: accepts one RV32I OP/OP-IMM word, reads operands from the
// register file, drives the external ALU for one cycle and writes the result back.
module alu_issue #(
   parameter int M_WIDTH   = 8,
   parameter int REG_COUNT = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_issue_if.master        bus,
   output logic               wb_valid,
   output logic [4:0]         wb_rd,
   output logic [M_WIDTH-1:0] wb_data,
   output logic               illegal,
   input  logic [4:0]         dbg_addr,
   output logic [M_WIDTH-1:0] dbg_data
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t             state;
   logic [31:0]        instr_q;
   logic [4:0]         rd_q;
   logic               bad_q;
   logic [M_WIDTH-1:0] rf [REG_COUNT];
   logic [M_WIDTH-1:0] rs1_val;
   logic [M_WIDTH-1:0] rs2_val;
   logic               unused_instr;

   assign bus.instr_ready = (state == IDLE);
   assign dbg_data        = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
   assign unused_instr    = ^instr_q;

   // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (instr_q[19:15] != 5'd0) rs1_val = rf[instr_q[19:15]];
      if (instr_q[24:20] != 5'd0) rs2_val = rf[instr_q[24:20]];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         instr_q          <= '0;
         rd_q             <= '0;
         bad_q            <= 1'b0;
         bus.alu_funct3   <= '0;
         bus.alu_modifier <= 1'b0;
         bus.alu_in1      <= '0;
         bus.alu_in2      <= '0;
         wb_valid         <= 1'b0;
         wb_rd            <= '0;
         wb_data          <= '0;
         illegal          <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.instr_valid) begin
                  instr_q <= bus.instr;
                  state   <= READ;
               end
            end
            READ: begin
               rd_q  <= instr_q[11:7];
               bad_q <= 1'b0;
               state <= EXEC;
               case (instr_q[6:0])
                  OPC_OP: begin
                     bus.alu_funct3   <= instr_q[14:12];
                     bus.alu_in1      <= rs1_val;
                     bus.alu_in2      <= rs2_val;
                     bus.alu_modifier <= instr_q[30];
                  end
                  OPC_OPIMM: begin
                     bus.alu_funct3   <= instr_q[14:12];
                     bus.alu_in1      <= rs1_val;
                     bus.alu_in2      <= instr_q[20 +: M_WIDTH];
                     // Only SRAI uses bit 30; there is no subtract-immediate.
                     bus.alu_modifier <= (instr_q[14:12] == 3'b101) ? instr_q[30] : 1'b0;
                  end
                  default: bad_q <= 1'b1;
               endcase
            end
            EXEC: begin
               state <= WB;
               wb_rd <= rd_q;
               if (bad_q) begin
                  illegal <= 1'b1;
               end else begin
                  wb_valid <= 1'b1;
                  wb_data  <= bus.alu_out;
               end
            end
            WB: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the register file is an architectural reset target, so every entry is cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      end else if (state == EXEC && !bad_q && rd_q != 5'd0) begin
         rf[rd_q] <= bus.alu_out;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, reset-abort sequence and
// randomized instructions compared against an architectural register-file model.
module tb_alu_issue;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         wb_valid;
   logic [4:0]   wb_rd;
   logic [W-1:0] wb_data;
   logic         illegal;
   logic [4:0]   dbg_addr;
   logic [W-1:0] dbg_data;

   int checks = 0;
   int errors = 0;

   alu_issue_if #(.M_WIDTH(W)) bus ();

   alu_issue #(.M_WIDTH(W), .REG_COUNT(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.master),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .illegal  (illegal),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational 8-bit RV32I ALU standing in for the real instance.
   function automatic logic [W-1:0] alu_fn(input logic [2:0] f3, input logic m,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      case (f3)
         3'd0: return m ? a - b : a + b;
         3'd1: return a << b[2:0];
         3'd2: return {7'd0, ($signed(a) < $signed(b))};
         3'd3: return {7'd0, (a < b)};
         3'd4: return a ^ b;
         3'd5: return m ? W'($signed(a) >>> b[2:0]) : a >> b[2:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   assign bus.alu_out = alu_fn(bus.alu_funct3, bus.alu_modifier, bus.alu_in1, bus.alu_in2);

   // Architectural model state
   logic [W-1:0] model_rf [32];
   logic [2:0]   last_f3;
   logic         last_m;
   logic [W-1:0] last_a;
   logic [W-1:0] last_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      last_f3 = '0;
      last_m  = 1'b0;
      last_a  = '0;
      last_b  = '0;
   endtask

   task automatic check_all_regs();
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         check($sformatf("reg_x%0d", i), 32'(dbg_data), 32'(model_rf[i]));
      end
   endtask

   // Issue one instruction, follow it through READ/EXEC/WB and compare against the model.
   // Returns in the WB cycle; with hold set, instr_valid stays high carrying junk while busy.
   task automatic issue(input logic [31:0] ins, input bit hold);
      logic [6:0] op;
      logic [2:0] f3;
      logic [4:0] rd;
      logic       legal;
      logic [W-1:0] res;
      int waitc;
      op    = ins[6:0];
      f3    = ins[14:12];
      rd    = ins[11:7];
      legal = 1'b1;
      waitc = 0;
      if (op == 7'h33) begin
         last_f3 = f3;
         last_m  = ins[30];
         last_a  = model_rf[ins[19:15]];
         last_b  = model_rf[ins[24:20]];
      end else if (op == 7'h13) begin
         last_f3 = f3;
         last_m  = (f3 == 3'd5) ? ins[30] : 1'b0;
         last_a  = model_rf[ins[19:15]];
         last_b  = ins[27:20];
      end else begin
         legal = 1'b0;
      end
      res = alu_fn(last_f3, last_m, last_a, last_b);

      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      while (!bus.instr_ready && waitc < 20) begin
         @(posedge clk);
         #1;
         waitc++;
      end
      if (!bus.instr_ready) begin
         check("ready_timeout", 32'(bus.instr_ready), 32'd1);
         bus.instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (hold) bus.instr = $urandom();
      else bus.instr_valid = 1'b0;
      check("busy_ready", 32'(bus.instr_ready), 32'd0);
      check("early_pulse", 32'(wb_valid | illegal), 32'd0);
      @(posedge clk);
      #1;
      check("exec_funct3", 32'(bus.alu_funct3), 32'(last_f3));
      check("exec_mod", 32'(bus.alu_modifier), 32'(last_m));
      check("exec_in1", 32'(bus.alu_in1), 32'(last_a));
      check("exec_in2", 32'(bus.alu_in2), 32'(last_b));
      check("exec_pulse", 32'(wb_valid | illegal), 32'd0);
      @(posedge clk);
      #1;
      check("wb_valid", 32'(wb_valid), 32'(legal));
      check("illegal", 32'(illegal), 32'(!legal));
      if (legal) begin
         check("wb_rd", 32'(wb_rd), 32'(rd));
         check("wb_data", 32'(wb_data), 32'(res));
         if (rd != 5'd0) begin
            model_rf[rd] = res;
            dbg_addr = rd;
            #1;
            check("dbg_rd", 32'(dbg_data), 32'(res));
         end
      end
   endtask

   typedef struct {
      logic [31:0]  ins;
      logic         ill;
      logic [4:0]   rd;
      logic [W-1:0] data;
      logic         mod;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [6:0]  op;
      vecs[0] = '{32'h00500093, 1'b0, 5'd1, 8'h05, 1'b0};  // ADDI x1,x0,5
      vecs[1] = '{32'h00700113, 1'b0, 5'd2, 8'h07, 1'b0};  // ADDI x2,x0,7
      vecs[2] = '{32'h402081B3, 1'b0, 5'd3, 8'hFE, 1'b1};  // SUB x3,x1,x2
      vecs[3] = '{32'h08000213, 1'b0, 5'd4, 8'h80, 1'b0};  // ADDI x4,x0,0x80
      vecs[4] = '{32'h40225293, 1'b0, 5'd5, 8'hE0, 1'b1};  // SRAI x5,x4,2
      vecs[5] = '{32'h00225313, 1'b0, 5'd6, 8'h20, 1'b0};  // SRLI x6,x4,2
      vecs[6] = '{32'h00900013, 1'b0, 5'd0, 8'h09, 1'b0};  // ADDI x0,x0,9
      vecs[7] = '{32'h0000A083, 1'b1, 5'd1, 8'h00, 1'b0};  // LW x1,0(x1)

      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      dbg_addr        = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.instr_ready), 32'd1);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_in1", 32'(bus.alu_in1), 32'd0);
      check("rst_in2", 32'(bus.alu_in2), 32'd0);
      check("rst_funct3", 32'(bus.alu_funct3), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].ins, 1'b0);
         if (vecs[i].ill) begin
            check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'd1);
         end else begin
            check($sformatf("vec%0d_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_data", i), 32'(wb_data), 32'(vecs[i].data));
         end
         check($sformatf("vec%0d_mod", i), 32'(bus.alu_modifier), 32'(vecs[i].mod));
      end
      dbg_addr = 5'd0;
      #1;
      check("x0_zero", 32'(dbg_data), 32'd0);
      dbg_addr = 5'd1;
      #1;
      check("x1_after_lw", 32'(dbg_data), 32'h05);
      check_all_regs();

      // Randomized stream, sometimes holding instr_valid high across busy cycles.
      for (int n = 0; n < 300; n++) begin
         r = $urandom();
         case ($urandom_range(0, 7))
            0, 1, 2: op = 7'h33;
            3, 4, 5: op = 7'h13;
            6:       op = 7'h03;
            default: op = 7'($urandom());
         endcase
         issue({r[31:7], op}, ($urandom_range(0, 3) == 0));
      end
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all_regs();

      // Reset during EXEC of ADDI x7,x0,3 abandons it.
      issue(32'h00000013, 1'b0);
      @(posedge clk);
      #1;
      bus.instr       = 32'h00300393;
      bus.instr_valid = 1'b1;
      check("pre_abort_ready", 32'(bus.instr_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_exec_in2", 32'(bus.alu_in2), 32'h03);
      rst = 1'b1;
      #2;
      model_reset();
      check("abort_ready", 32'(bus.instr_ready), 32'd1);
      check("abort_in2", 32'(bus.alu_in2), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("abort_no_wb", 32'(wb_valid | illegal), 32'd0);
         @(posedge clk);
         #1;
      end
      check("abort_ready_after", 32'(bus.instr_ready), 32'd1);
      dbg_addr = 5'd7;
      #1;
      check("abort_x7", 32'(dbg_data), 32'd0);
      check_all_regs();
      issue(32'h00300393, 1'b0);
      check("post_reset_data", 32'(wb_data), 32'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
